// File: rtl/ps2_pkg.sv
// Shared scan-code constants and key indices for the PS/2 key decoder.
// Byte values are PS/2 scan-code set 2.
package ps2_pkg;

    // Prefix bytes
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;

    // Extended-range keys (arrows)
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_UP     = 8'h75;

    // Plain keys
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_P      = 8'h4D;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_W      = 8'h1D;

    // Keyboard control and status bytes
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_OVR0   = 8'h00;
    localparam logic [7:0] SC_OVR1   = 8'hFF;

    localparam int unsigned NUM_KEYS = 6;
    localparam int unsigned KEY_W    = 3;

    typedef logic [KEY_W-1:0] key_idx_t;

    localparam key_idx_t KEY_LEFT   = 3'd0;
    localparam key_idx_t KEY_RIGHT  = 3'd1;
    localparam key_idx_t KEY_DOWN   = 3'd2;
    localparam key_idx_t KEY_ROTATE = 3'd3;
    localparam key_idx_t KEY_DROP   = 3'd4;
    localparam key_idx_t KEY_PAUSE  = 3'd5;

    typedef enum logic [0:0] {
        StIdle,
        StAck
    } dec_state_t;

    // Bytes that come from the keyboard controller itself rather than from a key.
    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return b inside {SC_ACK, SC_BAT, SC_ECHO, SC_RESEND, SC_OVR0, SC_OVR1};
    endfunction

endpackage

// File: rtl/ps2_scan_map.sv
// Combinational scan-code to game-key lookup; kept separate so the game layer
// can swap the key layout without touching the decoder FSM.
module ps2_scan_map
    import ps2_pkg::*;
#(
    parameter bit ALT_WASD = 1'b1
) (
    input  logic       ext_i,
    input  logic [7:0] byte_i,
    output logic       valid_o,
    output key_idx_t   key_o
);

    always_comb begin
        valid_o = 1'b0;
        key_o   = KEY_LEFT;
        if (ext_i) begin
            case (byte_i)
                SC_LEFT:  begin valid_o = 1'b1; key_o = KEY_LEFT;   end
                SC_RIGHT: begin valid_o = 1'b1; key_o = KEY_RIGHT;  end
                SC_DOWN:  begin valid_o = 1'b1; key_o = KEY_DOWN;   end
                SC_UP:    begin valid_o = 1'b1; key_o = KEY_ROTATE; end
                default:  ;
            endcase
        end else begin
            case (byte_i)
                SC_SPACE: begin valid_o = 1'b1;     key_o = KEY_DROP;   end
                SC_P:     begin valid_o = 1'b1;     key_o = KEY_PAUSE;  end
                SC_A:     begin valid_o = ALT_WASD; key_o = KEY_LEFT;   end
                SC_D:     begin valid_o = ALT_WASD; key_o = KEY_RIGHT;  end
                SC_S:     begin valid_o = ALT_WASD; key_o = KEY_DOWN;   end
                SC_W:     begin valid_o = ALT_WASD; key_o = KEY_ROTATE; end
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code parser: consumes receiver bytes and produces Tetris key
// press pulses, held levels and a bad-sequence pulse.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 500_000,
    parameter bit          ALT_WASD    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ready,
    input  logic [7:0]          data,
    output logic                rdn,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                bad_seq
);

    localparam int unsigned    CntW        = $clog2(TIMEOUT_CYC);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);

    dec_state_t          state_q, state_d;
    logic [7:0]          byte_q, byte_d;
    logic                rdn_q, rdn_d;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic                bad_q, bad_d;

    logic                map_valid;
    key_idx_t            map_key;

    ps2_scan_map #(
        .ALT_WASD (ALT_WASD)
    ) u_scan_map (
        .ext_i   (ext_q),
        .byte_i  (byte_q),
        .valid_o (map_valid),
        .key_o   (map_key)
    );

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        rdn_d   = 1'b1;
        ext_d   = ext_q;
        brk_d   = brk_q;
        cnt_d   = cnt_q;
        press_d = '0;
        held_d  = held_q;
        bad_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A pending prefix that waits too long is abandoned.
                if (ext_q || brk_q) begin
                    if (cnt_q == TimeoutLast) begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                        bad_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                if (ready) begin
                    byte_d  = data;
                    rdn_d   = 1'b0;
                    state_d = StAck;
                end
            end

            StAck: begin
                state_d = StIdle;
                cnt_d   = '0;
                if (byte_q == SC_EXT) begin
                    ext_d = 1'b1;
                end else if (byte_q == SC_BRK) begin
                    brk_d = 1'b1;
                end else begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    if (!is_ctrl_byte(byte_q)) begin
                        if (map_valid) begin
                            if (brk_q) begin
                                held_d[map_key] = 1'b0;
                            end else begin
                                // Typematic repeats of a held key give no new pulse.
                                press_d[map_key] = ~held_q[map_key];
                                held_d[map_key]  = 1'b1;
                            end
                        end else if (ext_q || brk_q) begin
                            bad_d = 1'b1;
                        end
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            byte_q  <= '0;
            rdn_q   <= 1'b1;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= '0;
            held_q  <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            rdn_q   <= rdn_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            held_q  <= held_d;
            bad_q   <= bad_d;
        end
    end

    assign rdn       = rdn_q;
    assign key_press = press_q;
    assign key_held  = held_q;
    assign bad_seq   = bad_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: transaction-level model checked every cycle,
// plus directed sequences with literal expectations.
module tb_ps2_key_decoder;

    localparam int unsigned T = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready;
    logic [7:0] data;
    logic       rdn;
    logic [5:0] key_press;
    logic [5:0] key_held;
    logic       bad_seq;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .TIMEOUT_CYC (T),
        .ALT_WASD    (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .data      (data),
        .rdn       (rdn),
        .key_press (key_press),
        .key_held  (key_held),
        .bad_seq   (bad_seq)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state: what the outputs must be after the latest edge.
    logic [5:0] m_press, m_held;
    logic       m_bad, m_busy, m_ext, m_brk, m_valid;
    logic [7:0] m_byte;
    int         m_cyc, m_t0;

    // Observation counters.
    int press_cnt [6];
    int bad_cnt, rdn_lows, rdn_run, rdn_run_max;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game-key table from scan-code set 2; -1 means no key.
    function automatic int map_key(input logic ext, input logic [7:0] b);
        int k;
        k = -1;
        if (ext) begin
            if (b == 8'h6B) k = 0;
            else if (b == 8'h74) k = 1;
            else if (b == 8'h72) k = 2;
            else if (b == 8'h75) k = 3;
        end else begin
            if (b == 8'h29) k = 4;
            else if (b == 8'h4D) k = 5;
            else if (b == 8'h1C) k = 0;
            else if (b == 8'h23) k = 1;
            else if (b == 8'h1B) k = 2;
            else if (b == 8'h1D) k = 3;
        end
        return k;
    endfunction

    task automatic model_decode(input logic [7:0] b);
        int k;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
            m_t0  = m_cyc;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
            m_t0  = m_cyc;
        end else begin
            if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
                k = map_key(m_ext, b);
                if (k >= 0) begin
                    if (m_brk) m_held[k] = 1'b0;
                    else begin
                        if (!m_held[k]) m_press[k] = 1'b1;
                        m_held[k] = 1'b1;
                    end
                end else if (m_ext || m_brk) begin
                    m_bad = 1'b1;
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // Model: a byte offered while idle is taken on one edge and decoded on the next.
    initial begin
        m_valid = 1'b0; m_busy = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
        m_press = '0; m_held = '0; m_bad = 1'b0; m_byte = '0;
        m_cyc = 0; m_t0 = 0;
        forever begin
            @(posedge clk);
            m_cyc++;
            if (rst) begin
                m_busy = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
                m_press = '0; m_held = '0; m_bad = 1'b0;
                m_valid = 1'b1;
            end else begin
                m_press = '0;
                m_bad   = 1'b0;
                if (m_busy) begin
                    model_decode(m_byte);
                    m_busy = 1'b0;
                end else begin
                    if ((m_ext || m_brk) && (m_cyc - m_t0 == T)) begin
                        m_ext = 1'b0;
                        m_brk = 1'b0;
                        m_bad = 1'b1;
                    end
                    if (ready) begin
                        m_busy = 1'b1;
                        m_byte = data;
                    end
                end
            end
        end
    end

    // Compare process, away from the active edge.
    initial begin
        bad_cnt = 0; rdn_lows = 0; rdn_run = 0; rdn_run_max = 0;
        for (int i = 0; i < 6; i++) press_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("rdn", {31'd0, rdn}, {31'd0, !m_busy});
                check("key_press", {26'd0, key_press}, {26'd0, m_press});
                check("key_held", {26'd0, key_held}, {26'd0, m_held});
                check("bad_seq", {31'd0, bad_seq}, {31'd0, m_bad});
                for (int i = 0; i < 6; i++) press_cnt[i] += int'(key_press[i]);
                bad_cnt += int'(bad_seq);
                if (rdn == 1'b0) begin
                    rdn_lows++;
                    rdn_run++;
                end else begin
                    rdn_run = 0;
                end
                if (rdn_run > rdn_run_max) rdn_run_max = rdn_run;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Receiver side: offer a byte, wait for the read strobe, drop ready on the edge ending it.
    task automatic send(input logic [7:0] b);
        int w;
        ready = 1'b1;
        data  = b;
        w = 0;
        do begin
            tick(1);
            w++;
        end while (rdn !== 1'b0 && w < 20);
        if (rdn !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake: rdn stayed %b, required 0 for byte %0h", rdn, b);
        end
        tick(1);
        ready = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        ready = 1'b0;
        tick(1);
        rst = 1'b0;
    endtask

    function automatic int press_sum();
        int s;
        s = 0;
        for (int i = 0; i < 6; i++) s += press_cnt[i];
        return s;
    endfunction

    initial begin
        int p0, p1, p4, ps, b0, l0;
        rst = 1'b1; ready = 1'b0; data = 8'h00;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("reset_rdn", {31'd0, rdn}, 32'd1);
        check("reset_held", {26'd0, key_held}, 32'd0);
        check("reset_press", {26'd0, key_press}, 32'd0);
        check("reset_bad", {31'd0, bad_seq}, 32'd0);

        // Extended left arrow: pulse on the decode edge of the second byte.
        send(8'hE0);
        check("t1_prefix_no_press", {26'd0, key_press}, 32'd0);
        send(8'h6B);
        check("t1_press", {26'd0, key_press}, 32'b000001);
        check("t1_held", {26'd0, key_held}, 32'b000001);
        tick(1);
        check("t1_press_one_cycle", {26'd0, key_press}, 32'd0);

        // Typematic repeats then release.
        do_reset();
        tick(1);
        p0 = press_cnt[0];
        repeat (3) begin
            send(8'hE0);
            send(8'h6B);
            tick(2);
        end
        check("t2_held_during_repeat", {26'd0, key_held}, 32'b000001);
        send(8'hE0); send(8'hF0); send(8'h6B);
        tick(1);
        check("t2_single_pulse", press_cnt[0] - p0, 32'd1);
        check("t2_released", {26'd0, key_held}, 32'd0);

        // Overlapping keys.
        do_reset();
        tick(1);
        p1 = press_cnt[1]; p4 = press_cnt[4]; ps = press_sum();
        send(8'h29); send(8'hE0); send(8'h74);
        check("t3_both_held", {26'd0, key_held}, 32'b010010);
        send(8'hF0); send(8'h29);
        check("t3_drop_released", {26'd0, key_held}, 32'b000010);
        tick(1);
        check("t3_drop_pulse", press_cnt[4] - p4, 32'd1);
        check("t3_right_pulse", press_cnt[1] - p1, 32'd1);
        check("t3_total_pulses", press_sum() - ps, 32'd2);

        // Back-to-back bytes with ready held high.
        do_reset();
        tick(1);
        l0 = rdn_lows; ps = press_sum();
        send(8'h1D); send(8'hF0); send(8'h1D); send(8'h23); send(8'hF0); send(8'h23);
        tick(1);
        check("t4_one_strobe_per_byte", rdn_lows - l0, 32'd6);
        check("t4_rdn_max_run", rdn_run_max, 32'd1);
        check("t4_pulses", press_sum() - ps, 32'd2);
        check("t4_held", {26'd0, key_held}, 32'd0);

        // Prefix timeout, then plain 6B and control bytes do nothing.
        do_reset();
        tick(1);
        b0 = bad_cnt; ps = press_sum();
        send(8'hE0);
        tick(T - 1);
        check("t5_no_early_timeout", {31'd0, bad_seq}, 32'd0);
        tick(1);
        check("t5_timeout_pulse", {31'd0, bad_seq}, 32'd1);
        tick(1);
        send(8'h6B);
        send(8'hFA);
        send(8'hAA);
        tick(1);
        check("t5_no_key", {26'd0, key_held}, 32'd0);
        check("t5_no_press", press_sum() - ps, 32'd0);
        check("t5_one_bad", bad_cnt - b0, 32'd1);

        // Unknown extended key and released unknown key are bad; control byte clears prefix.
        b0 = bad_cnt;
        send(8'hE0); send(8'h12);
        send(8'hF0); send(8'h44);
        send(8'hE0); send(8'hFA); send(8'h6B);
        send(8'h12);
        send(8'hE1); send(8'h14); send(8'h77);
        tick(1);
        check("bad_unknown_prefixed", bad_cnt - b0, 32'd2);
        check("bad_no_key", {26'd0, key_held}, 32'd0);

        // Pause key and reset mid-sequence.
        do_reset();
        send(8'h4D);
        check("pause_press", {26'd0, key_press}, 32'b100000);
        send(8'hE0); send(8'h72);
        check("t6_held", {26'd0, key_held}, 32'b100100);
        send(8'hE0); send(8'hF0);
        rst = 1'b1;
        tick(1);
        check("t6_rst_held", {26'd0, key_held}, 32'd0);
        check("t6_rst_press", {26'd0, key_press}, 32'd0);
        check("t6_rst_bad", {31'd0, bad_seq}, 32'd0);
        check("t6_rst_rdn", {31'd0, rdn}, 32'd1);
        rst = 1'b0;
        send(8'h72);
        tick(1);
        check("t6_context_lost", {26'd0, key_held}, 32'd0);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
